// File: rtl/bw_io_dtl_bscan_pkg.sv
// Shared definitions for the DTL pad boundary-scan capture segment.
// Holds per-pad chain layout constants and the {oe,d} pair type.
package bw_io_dtl_bscan_pkg;

    localparam int BSCAN_BITS_PER_PAD = 2;
    localparam int BSCAN_D_OFS        = 0;
    localparam int BSCAN_OE_OFS       = 1;

    // Packed so that oe lands on the odd chain bit and d on the even bit.
    typedef struct packed {
        logic oe;
        logic d;
    } bscan_pair_t;

endpackage

// File: rtl/bw_io_dtl_bscan_sync2.sv
// Two-flop synchroniser for the pad observe vector.
// Ports: clk, rst (async high), i_d (async in), o_q (synchronised out).
module bw_io_dtl_bscan_sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/bw_io_dtl_bscan_cap.sv
// Boundary-scan capture/shift/update segment for NPAD DTL pads.
// Ports: clk, rst, intest_d/oe (async observe), capture/shift/update_dr
// strobes, extest, clr_err, scan_in/out, upd_d/oe, shift_cnt, mis_err.
module bw_io_dtl_bscan_cap
    import bw_io_dtl_bscan_pkg::*;
#(
    parameter int NPAD = 4,
    parameter int CW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NPAD-1:0] intest_d,
    input  logic [NPAD-1:0] intest_oe,
    input  logic            capture_dr,
    input  logic            shift_dr,
    input  logic            update_dr,
    input  logic            extest,
    input  logic            clr_err,
    input  logic            scan_in,
    output logic            scan_out,
    output logic [NPAD-1:0] upd_d,
    output logic [NPAD-1:0] upd_oe,
    output logic [CW-1:0]   shift_cnt,
    output logic            mis_err
);

    localparam int L = NPAD * BSCAN_BITS_PER_PAD;

    bscan_pair_t [NPAD-1:0] w_obs;
    bscan_pair_t [NPAD-1:0] w_upd;
    logic [L-1:0]           w_sync;
    logic [L-1:0]           w_upd_vec;

    logic [L-1:0]    r_sr;
    logic [NPAD-1:0] r_upd_d;
    logic [NPAD-1:0] r_upd_oe;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    always_comb begin
        w_obs = '0;
        w_upd = '0;
        for (int i = 0; i < NPAD; i++) begin
            w_obs[i].d  = intest_d[i];
            w_obs[i].oe = intest_oe[i];
            w_upd[i].d  = r_upd_d[i];
            w_upd[i].oe = r_upd_oe[i];
        end
    end

    assign w_upd_vec = w_upd;

    bw_io_dtl_bscan_sync2 #(.W(L)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (w_obs),
        .o_q (w_sync)
    );

    // Capture outranks shift, which outranks update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr     <= '0;
            r_upd_d  <= '0;
            r_upd_oe <= '0;
            r_cnt    <= '0;
        end else if (capture_dr) begin
            r_sr  <= w_sync;
            r_cnt <= '0;
        end else if (shift_dr) begin
            r_sr <= {scan_in, r_sr[L-1:1]};
            if (r_cnt != '1)
                r_cnt <= r_cnt + CW'(1);
        end else if (update_dr) begin
            for (int i = 0; i < NPAD; i++) begin
                r_upd_d[i]  <= r_sr[BSCAN_BITS_PER_PAD*i+BSCAN_D_OFS];
                r_upd_oe[i] <= r_sr[BSCAN_BITS_PER_PAD*i+BSCAN_OE_OFS];
            end
        end
    end

    // A mismatch set in the same cycle as a clear must win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (capture_dr && extest && (w_sync != w_upd_vec))
            r_err <= 1'b1;
        else if (clr_err)
            r_err <= 1'b0;
    end

    assign scan_out  = r_sr[0];
    assign upd_d     = r_upd_d;
    assign upd_oe    = r_upd_oe;
    assign shift_cnt = r_cnt;
    assign mis_err   = r_err;

endmodule

// File: tb/tb_bw_io_dtl_bscan_cap.sv
// Self-checking bench for bw_io_dtl_bscan_cap (NPAD=4 main, NPAD=1/CW=3 small).
// Directed vectors plus a per-cycle behavioural model comparison.
module tb_bw_io_dtl_bscan_cap;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] intest_d = '0;
    logic [3:0] intest_oe = '0;
    logic       capture_dr = 0, shift_dr = 0, update_dr = 0;
    logic       extest = 0, clr_err = 0, scan_in = 0;
    logic       scan_out;
    logic [3:0] upd_d, upd_oe;
    logic [5:0] shift_cnt;
    logic       mis_err;

    logic       s_d = 0, s_oe = 0;
    logic       s_cap = 0, s_sh = 0, s_si = 0;
    logic       s_so;
    logic [0:0] s_ud, s_uoe;
    logic [2:0] s_cnt;
    logic       s_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bw_io_dtl_bscan_cap #(.NPAD(4), .CW(6)) dut (
        .clk(clk), .rst(rst),
        .intest_d(intest_d), .intest_oe(intest_oe),
        .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .extest(extest),
        .clr_err(clr_err), .scan_in(scan_in),
        .scan_out(scan_out), .upd_d(upd_d), .upd_oe(upd_oe),
        .shift_cnt(shift_cnt), .mis_err(mis_err)
    );

    bw_io_dtl_bscan_cap #(.NPAD(1), .CW(3)) dut_s (
        .clk(clk), .rst(rst),
        .intest_d(s_d), .intest_oe(s_oe),
        .capture_dr(s_cap), .shift_dr(s_sh),
        .update_dr(1'b0), .extest(1'b0),
        .clr_err(1'b0), .scan_in(s_si),
        .scan_out(s_so), .upd_d(s_ud), .upd_oe(s_uoe),
        .shift_cnt(s_cnt), .mis_err(s_err)
    );

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] ilv(logic [3:0] d, logic [3:0] oe);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i]   = d[i];
            r[2*i+1] = oe[i];
        end
        return r;
    endfunction

    logic [7:0] pad_hist [2];
    logic [7:0] m_sr;
    logic [3:0] m_ud, m_uoe;
    int         m_cnt;
    logic       m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_hist[0] <= '0;
            pad_hist[1] <= '0;
            m_sr  <= '0;
            m_ud  <= '0;
            m_uoe <= '0;
            m_cnt <= 0;
            m_err <= 1'b0;
        end else begin
            pad_hist[0] <= ilv(intest_d, intest_oe);
            pad_hist[1] <= pad_hist[0];
            if (capture_dr) begin
                m_sr  <= pad_hist[1];
                m_cnt <= 0;
            end else if (shift_dr) begin
                m_sr  <= (m_sr >> 1) | (8'(scan_in) << 7);
                m_cnt <= (m_cnt >= 63) ? 63 : m_cnt + 1;
            end else if (update_dr) begin
                for (int i = 0; i < 4; i++) begin
                    m_ud[i]  <= m_sr[2*i];
                    m_uoe[i] <= m_sr[2*i+1];
                end
            end
            if (capture_dr && extest && pad_hist[1] != ilv(m_ud, m_uoe))
                m_err <= 1'b1;
            else if (clr_err)
                m_err <= 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("mdl_scan_out", scan_out, m_sr[0]);
        chk("mdl_upd_d", upd_d, m_ud);
        chk("mdl_upd_oe", upd_oe, m_uoe);
        chk("mdl_shift_cnt", shift_cnt, m_cnt);
        chk("mdl_mis_err", mis_err, m_err);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(logic cap, logic sh, logic up, logic si);
        @(negedge clk);
        capture_dr = cap;
        shift_dr   = sh;
        update_dr  = up;
        scan_in    = si;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0);
    endtask

    task automatic shift_in(logic [7:0] v);
        for (int k = 0; k < 8; k++)
            cyc(0, 1, 0, v[k]);
    endtask

    logic [7:0] exp_seq;

    initial begin
        exp_seq = 8'b1110_0100;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_scan_out", scan_out, 0);
        chk("rst_upd_d", upd_d, 0);
        chk("rst_cnt", shift_cnt, 0);
        @(negedge clk);
        rst = 0;

        // capture latency: hold two cycles, then capture
        intest_d  = 4'b1010;
        intest_oe = 4'b1100;
        idle();
        idle();
        cyc(1, 0, 0, 0);
        chk("cap_seq0", scan_out, exp_seq[0]);
        for (int k = 1; k < 8; k++) begin
            cyc(0, 1, 0, 0);
            chk($sformatf("cap_seq%0d", k), scan_out, exp_seq[k]);
        end
        cyc(0, 1, 0, 0);
        chk("cap_cnt8", shift_cnt, 8);
        chk("cap_zero_fill", scan_out, 0);

        // too-early capture sees the old pad value
        intest_d  = 4'b0101;
        intest_oe = 4'b0011;
        idle();
        cyc(1, 0, 0, 0);
        chk("early_old", scan_out, 0);
        cyc(1, 0, 0, 0);
        chk("late_new", scan_out, 1);

        // shift then update
        shift_in(8'b1011_0110);
        cyc(0, 0, 1, 0);
        chk("upd_d", upd_d, 4'b0110);
        chk("upd_oe", upd_oe, 4'b1101);

        // priority
        cyc(1, 1, 1, 0);
        chk("pri_cnt", shift_cnt, 0);
        chk("pri_sr", scan_out, 1);
        chk("pri_upd_d", upd_d, 4'b0110);
        cyc(0, 1, 1, 0);
        chk("pri_sh_cnt", shift_cnt, 1);
        chk("pri_sh_upd", upd_oe, 4'b1101);

        // loopback mismatch
        shift_in(8'hFF);
        cyc(0, 0, 1, 0);
        chk("lb_upd_d", upd_d, 4'hF);
        chk("lb_upd_oe", upd_oe, 4'hF);
        extest    = 1;
        intest_d  = 4'hE;
        intest_oe = 4'hF;
        idle();
        idle();
        cyc(1, 0, 0, 0);
        chk("lb_set", mis_err, 1);
        idle();
        chk("lb_sticky", mis_err, 1);
        clr_err = 1;
        idle();
        chk("lb_clr", mis_err, 0);
        cyc(1, 0, 0, 0);
        chk("lb_set_wins", mis_err, 1);
        intest_d = 4'hF;
        idle();
        idle();
        cyc(1, 0, 0, 0);
        chk("lb_match_clr", mis_err, 0);
        clr_err = 0;
        extest  = 0;

        // reset mid-shift
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("arst_scan_out", scan_out, 0);
        chk("arst_upd_d", upd_d, 0);
        chk("arst_upd_oe", upd_oe, 0);
        chk("arst_cnt", shift_cnt, 0);
        chk("arst_err", mis_err, 0);
        shift_dr = 0;
        @(negedge clk);
        rst = 0;

        // small instance: NPAD=1, CW=3 saturation
        s_d  = 1;
        s_oe = 0;
        repeat (2) @(negedge clk);
        s_cap = 1;
        @(negedge clk);
        s_cap = 0;
        chk("s_cap_so", s_so, 1);
        s_sh = 1;
        @(negedge clk);
        chk("s_sh1_so", s_so, 0);
        repeat (9) @(negedge clk);
        s_sh = 0;
        chk("s_sat", s_cnt, 7);
        @(negedge clk);
        chk("s_hold", s_cnt, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
